// File: rtl/tx_rx_pkg.sv
// Definitions shared by the pattern transmitter and the downstream pattern receiver.
package tx_rx_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

   localparam int         DEF_WIDTH   = 9;
   localparam logic [8:0] DEF_PATTERN = 9'b010101010;
   localparam int         FCNT_W      = 8;
endpackage

// File: rtl/pattern_shifter.sv
// Loadable LSB-first right-shift register with a bit counter flagging the last bit of a frame.
module pattern_shifter #(
   parameter int LEN = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           shift,
   input  logic [LEN-1:0] value,
   output logic           bit0,
   output logic           last_bit
);
   localparam int CW = $clog2(LEN + 1);

   logic [LEN-1:0] sreg;
   logic [CW-1:0]  cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= value;
         cnt  <= '0;
      end else if (shift) begin
         sreg <= {1'b0, sreg[LEN-1:1]};
         cnt  <= cnt + CW'(1);
      end
   end

   assign bit0     = sreg[0];
   assign last_bit = (cnt == CW'(LEN - 1));
endmodule

// File: rtl/pattern_transmitter.sv
// Repeating serial pattern transmitter with inter-frame gap and abort.
// Optional: define PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module pattern_transmitter
   import tx_rx_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] PATTERN    = DEF_PATTERN,
   parameter int               GAP_CYCLES = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [FCNT_W-1:0] i_repeat,
   input  logic              i_abort,
   output logic              o_serial,
   output logic              o_busy,
   output logic              o_done,
   output logic [FCNT_W-1:0] o_frame_cnt
);
`ifdef PATTERN_TX_PARITY_EN
   localparam int FLEN = WIDTH + 1;
   logic [FLEN-1:0] frame;
   assign frame = {^PATTERN, PATTERN};
`else
   localparam int FLEN = WIDTH;
   logic [FLEN-1:0] frame;
   assign frame = PATTERN;
`endif

   state_t            state, nstate;
   logic [FCNT_W-1:0] rem;
   logic [7:0]        gap_cnt;
   logic              load, shift, bit0, last_bit, more, gap_end;
   logic              serial_d, busy_d, done_d;

   assign more    = (rem > FCNT_W'(1));
   assign gap_end = (gap_cnt == 8'(GAP_CYCLES - 1));

   pattern_shifter #(.LEN(FLEN)) u_shifter (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .load     (load),
      .shift    (shift),
      .value    (frame),
      .bit0     (bit0),
      .last_bit (last_bit)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:  if (i_start) nstate = SHIFT;
         SHIFT: if (last_bit) nstate = !more ? DONE : ((GAP_CYCLES == 0) ? SHIFT : GAP);
         GAP:   if (gap_end) nstate = SHIFT;
         DONE:  nstate = IDLE;
      endcase
      if (i_abort) nstate = IDLE;
   end

   // Next values of the registered outputs plus shifter control; abort squashes everything.
   always_comb begin
      load     = 1'b0;
      shift    = 1'b0;
      serial_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state)
         IDLE:  load = i_start;
         SHIFT: begin
            shift    = 1'b1;
            serial_d = bit0;
            busy_d   = 1'b1;
            load     = last_bit && more && (GAP_CYCLES == 0);
         end
         GAP: begin
            busy_d = 1'b1;
            load   = gap_end;
         end
         DONE:  done_d = 1'b1;
      endcase
      if (i_abort) begin
         load     = 1'b0;
         shift    = 1'b0;
         serial_d = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_serial    <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_frame_cnt <= '0;
         rem         <= '0;
         gap_cnt     <= '0;
      end else begin
         o_serial <= serial_d;
         o_busy   <= busy_d;
         o_done   <= done_d;
         if (state == IDLE && i_start && !i_abort) begin
            o_frame_cnt <= '0;
            rem         <= (i_repeat == '0) ? FCNT_W'(1) : i_repeat;
         end else if (state == SHIFT && last_bit && !i_abort) begin
            if (o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
            rem <= rem - FCNT_W'(1);
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      end
   end
endmodule

// File: tb/tb_pattern_transmitter.sv
// Randomized bench for pattern_transmitter against a frame-stream reference model.
module tb_pattern_transmitter;
   localparam int GAP = 2;
`ifdef PATTERN_TX_PARITY_EN
   localparam int FLEN = 10;
`else
   localparam int FLEN = 9;
`endif

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [7:0] rep = 8'd0;
   logic       serial, busy, done;
   logic [7:0] fcnt;
   int         total = 0, bad = 0, last_cnt = 0;
   logic [8:0] pat = 9'b010101010;
   int         e_ser[$], e_busy[$], e_done[$], e_cnt[$];

   pattern_transmitter #(.GAP_CYCLES(GAP)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_repeat    (rep),
      .i_abort     (abort),
      .o_serial    (serial),
      .o_busy      (busy),
      .o_done      (done),
      .o_frame_cnt (fcnt)
   );

   always #5 clk = ~clk;

   function automatic int frame_bit(input int b);
      if (b < 9) return int'(pat[b]);
      return int'(^pat);
   endfunction

   function automatic int done_idx(input int r_in);
      int r = (r_in == 0) ? 1 : r_in;
      return r * FLEN + (r - 1) * GAP + 1;
   endfunction

   function automatic void add(input int s, input int b, input int d, input int c);
      e_ser.push_back(s); e_busy.push_back(b); e_done.push_back(d); e_cnt.push_back(c);
   endfunction

   // Index c = observation after the c-th clock edge following the accepted start.
   function automatic void build_model(input int r_in, input int abort_at);
      int r = (r_in == 0) ? 1 : r_in;
      int held;
      e_ser.delete(); e_busy.delete(); e_done.delete(); e_cnt.delete();
      add(0, 0, 0, 0);
      for (int f = 0; f < r; f++) begin
         for (int b = 0; b < FLEN; b++) add(frame_bit(b), 1, 0, f + ((b == FLEN - 1) ? 1 : 0));
         if (f < r - 1) for (int g = 0; g < GAP; g++) add(0, 1, 0, f + 1);
      end
      add(0, 0, 1, r);
      add(0, 0, 0, r);
      if (abort_at > 0) begin
         held = e_cnt[abort_at - 1];
         for (int c = abort_at; c < e_ser.size(); c++) begin
            e_ser[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_cnt[c] = held;
         end
      end
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({serial, busy, done, fcnt} !== 11'd0) begin
         bad++; $display("FAIL reset_held got ser=%0b busy=%0b done=%0b cnt=%0d exp all 0", serial, busy, done, fcnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({serial, busy, done, fcnt} !== 11'd0) begin
         bad++; $display("FAIL reset_release got ser=%0b busy=%0b done=%0b cnt=%0d exp all 0", serial, busy, done, fcnt);
      end
   endtask

   task automatic test_frames();
      int reps[3] = '{1, 3, 0};
      for (int t = 0; t < 3; t++) begin
         build_model(reps[t], 0);
         rep = 8'(reps[t]); start = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int c = 0; c < e_ser.size(); c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (serial !== 1'(e_ser[c]) || busy !== 1'(e_busy[c]) || done !== 1'(e_done[c]) || fcnt !== 8'(e_cnt[c])) begin
               bad++;
               $display("FAIL frames rep=%0d idx=%0d got ser=%0b busy=%0b done=%0b cnt=%0d exp ser=%0d busy=%0d done=%0d cnt=%0d",
                        reps[t], c, serial, busy, done, fcnt, e_ser[c], e_busy[c], e_done[c], e_cnt[c]);
            end
         end
         last_cnt = e_cnt[e_cnt.size() - 1];
      end
   endtask

   task automatic test_start_ignored();
      int ign_at = 5;
      build_model(2, 0);
      rep = 8'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < e_ser.size(); c++) begin
         if (c > 0) @(negedge clk);
         total++;
         if (serial !== 1'(e_ser[c]) || busy !== 1'(e_busy[c]) || done !== 1'(e_done[c]) || fcnt !== 8'(e_cnt[c])) begin
            bad++;
            $display("FAIL start_ignored idx=%0d got ser=%0b busy=%0b done=%0b cnt=%0d exp ser=%0d busy=%0d done=%0d cnt=%0d",
                     c, serial, busy, done, fcnt, e_ser[c], e_busy[c], e_done[c], e_cnt[c]);
         end
         start = (c + 1 == ign_at);
      end
      start = 1'b0;
      last_cnt = e_cnt[e_cnt.size() - 1];
   endtask

   task automatic test_abort();
      int abort_at = FLEN + GAP + 1 + 5 + 1;
      build_model(4, abort_at);
      rep = 8'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < e_ser.size(); c++) begin
         if (c > 0) @(negedge clk);
         total++;
         if (serial !== 1'(e_ser[c]) || busy !== 1'(e_busy[c]) || done !== 1'(e_done[c]) || fcnt !== 8'(e_cnt[c])) begin
            bad++;
            $display("FAIL abort idx=%0d got ser=%0b busy=%0b done=%0b cnt=%0d exp ser=%0d busy=%0d done=%0d cnt=%0d",
                     c, serial, busy, done, fcnt, e_ser[c], e_busy[c], e_done[c], e_cnt[c]);
         end
         abort = (c + 1 == abort_at);
      end
      abort = 1'b0;
      last_cnt = e_cnt[e_cnt.size() - 1];
   endtask

   task automatic test_random();
      for (int run = 0; run < 8; run++) begin
         int r = int'($urandom_range(0, 4));
         int d = done_idx(r);
         int abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, d)) : 0;
         int ign_at = int'($urandom_range(1, (abort_at > 0) ? abort_at : d));
         build_model(r, abort_at);
         rep = 8'(r); start = 1'b1;
         @(negedge clk); start = 1'b0; rep = 8'($urandom);
         for (int c = 0; c < e_ser.size(); c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (serial !== 1'(e_ser[c]) || busy !== 1'(e_busy[c]) || done !== 1'(e_done[c]) || fcnt !== 8'(e_cnt[c])) begin
               bad++;
               $display("FAIL random run=%0d rep=%0d abort_at=%0d idx=%0d got ser=%0b busy=%0b done=%0b cnt=%0d exp ser=%0d busy=%0d done=%0d cnt=%0d",
                        run, r, abort_at, c, serial, busy, done, fcnt, e_ser[c], e_busy[c], e_done[c], e_cnt[c]);
            end
            abort = (c + 1 == abort_at);
            start = (c + 1 == ign_at);
         end
         abort = 1'b0; start = 1'b0;
         last_cnt = e_cnt[e_cnt.size() - 1];
      end
   endtask

   task automatic test_abort_start();
      start = 1'b1; abort = 1'b1; rep = 8'd5;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); start = 1'b0; abort = 1'b0;
         total++;
         if (busy !== 1'b0 || serial !== 1'b0 || done !== 1'b0 || fcnt !== 8'(last_cnt)) begin
            bad++;
            $display("FAIL abort_start idx=%0d got ser=%0b busy=%0b done=%0b cnt=%0d exp ser=0 busy=0 done=0 cnt=%0d",
                     c, serial, busy, done, fcnt, last_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      rep = 8'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL reset_mid_busy got busy=%0b exp 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({serial, busy, done, fcnt} !== 11'd0) begin
         bad++; $display("FAIL reset_mid_async got ser=%0b busy=%0b done=%0b cnt=%0d exp all 0", serial, busy, done, fcnt);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({serial, busy, done, fcnt} !== 11'd0) begin
         bad++; $display("FAIL reset_mid_after got ser=%0b busy=%0b done=%0b cnt=%0d exp all 0", serial, busy, done, fcnt);
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_start_ignored();
      test_abort();
      test_random();
      test_abort_start();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pattern_transmitter.md
# pattern_transmitter

- Serializes a fixed 9-bit month/date pattern onto a one-bit line, LSB first, one bit per clock.
- Sits directly upstream of the pattern-matching receiver and drives its serial input.
- Supports a programmable number of back-to-back frames, an idle gap between frames, and abort.
- Reports busy, a done pulse and a completed-frame count to the count stage.

## Interface

- `PATTERN`, default 9'b010101010: frame payload; bit 0 is sent first.
- `WIDTH`, default 9: payload bits per frame.
- `GAP_CYCLES`, default 0: idle cycles (line low) between consecutive frames; range 0–255.
- `i_clk`, input, 1: single clock; all logic on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: start request; sampled only in IDLE.
- `i_repeat`, input, 8: number of frames to send; latched when `i_start` is accepted.
- `i_abort`, input, 1: immediate stop; wins over every other input.
- `o_serial`, output, 1: serial data, registered.
- `o_busy`, output, 1: high while a transmission is in progress.
- `o_done`, output, 1: one-cycle pulse after the last bit of the last frame.
- `o_frame_cnt`, output, 8: frames completed in the current or most recent run.

## Operation

- Reset values: all outputs 0, state IDLE, shift register 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE → SHIFT when `i_start`=1.
  - On entry: load shift register with `PATTERN`, bit counter = 0, latch `i_repeat`, clear `o_frame_cnt`.
  - `i_repeat`=0 is treated as 1.
- SHIFT:
  - `o_serial` <= shift_reg[0]; shift right with 0 fill; bit counter++.
  - When the last bit is driven, `o_frame_cnt`++.
  - If frames remain: go to GAP, or reload `PATTERN` and stay in SHIFT when `GAP_CYCLES`=0.
  - Otherwise go to DONE.
- GAP: `o_serial`=0 for `GAP_CYCLES` cycles, then reload `PATTERN` and go to SHIFT.
- DONE: `o_done`=1 for one cycle, `o_serial`=0, then IDLE.
- `i_start` is ignored in SHIFT, GAP and DONE. No queuing.
- `i_abort` in any state:
  - Next cycle: state IDLE, `o_serial`=0, `o_busy`=0.
  - No `o_done`; `o_frame_cnt` holds.
- `i_abort` and `i_start` in the same IDLE cycle: abort wins, no start.
- `o_frame_cnt` saturates at 255.
- Reset asserted mid-frame: all outputs clear asynchronously; the partial frame is lost.

## Timing

- `i_start` accepted at edge N:
  - `o_busy`=1 from N+1.
  - Payload bit k appears on `o_serial` during cycle N+1+k.
- Frame length is `WIDTH` cycles (`WIDTH`+1 with parity). Frame period is frame length + `GAP_CYCLES`.
- `o_done` is high in the cycle after the last bit of the last frame. `o_busy` drops in that same cycle.
- Earliest next start is accepted on the cycle after `o_done`.
- No combinational path from any input to any output.

## Configuration

- `PATTERN_TX_PARITY_EN`
  - Defined: after the `WIDTH` payload bits, one even-parity bit is sent (XOR of `PATTERN`). Frame length is `WIDTH`+1; all timing shifts accordingly.
  - Undefined: no parity bit; frame length is `WIDTH`.

## Structure

- Shared package `tx_rx_pkg` holds:
  - the state enum (IDLE/SHIFT/GAP/DONE);
  - the default `PATTERN` constant 9'b010101010 and `WIDTH`, shared with the receiver;
  - the frame-count width constant (8).
- One sub-module, `pattern_shifter`:
  - loadable right-shift register plus bit counter;
  - signals `last_bit`.
- The FSM, gap counter, frame counter and abort logic stay in the top.

## Test plan

- Reset, then `i_start`=1 for one cycle with `i_repeat`=1 → `o_serial` = 0,1,0,1,0,1,0,1,0 on cycles N+1..N+9; `o_done` at N+10; `o_frame_cnt`=1.
- `i_repeat`=3, `GAP_CYCLES`=2 → three 9-bit frames, each separated by exactly 2 low cycles; `o_frame_cnt` steps 1,2,3; single `o_done` at N+32.
- `i_repeat`=0 → behaves exactly as `i_repeat`=1.
- Pulse `i_start` again at bit 4 of a frame → ignored; output stream unchanged.
- `i_abort` at bit 5 of frame 2 with `i_repeat`=4 → next cycle `o_busy`=0, `o_serial`=0, no `o_done`, `o_frame_cnt`=1.
- With `PATTERN_TX_PARITY_EN` defined and `i_repeat`=1 → 9 payload bits then parity 0 at N+10; `o_done` at N+11. Then drop `i_rst_n` mid-frame → all outputs 0 immediately.
